// File: rtl/hazard_ctrl.sv
// Hazard control: operand forwarding select, load-use stall, mtc0 drain and divider stall.
// Optional stall-cycle counter when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
  parameter int NSRC = 2,
  parameter int NSTG = 3,
  parameter int AW   = 5,
  localparam int SELW = $clog2(NSTG + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   src_addr,
  input  logic [NSTG-1:0]      stg_valid,
  input  logic [NSTG*AW-1:0]   stg_dst,
  input  logic [NSTG-1:0]      stg_load,
  input  logic                 op_mtc0,
  input  logic                 op_div,
  input  logic                 div_done,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 stall,
  output logic                 ex_bubble,
  output logic                 div_start
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CP0WAIT,
    DIVBUSY,
    RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   cnt_q, cnt_d;
  logic [NSRC*SELW-1:0] fwd_raw;
  logic              hazard;
  logic              stall_c;
  logic              start_c;
  logic [SELW-1:0]   sel;
  logic              sel_ld;

  // Youngest producer wins: scan oldest to youngest so EX overrides.
  always_comb begin
    fwd_raw = '0;
    hazard  = 1'b0;
    sel     = '0;
    sel_ld  = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      sel    = '0;
      sel_ld = 1'b0;
      for (int k = NSTG - 1; k >= 0; k--) begin
        if (stg_valid[k] &&
            stg_dst[k*AW +: AW] != '0 &&
            src_addr[s*AW +: AW] == stg_dst[k*AW +: AW]) begin
          sel    = SELW'(k + 1);
          sel_ld = stg_load[k];
        end
      end
      if (sel_ld) hazard = 1'b1;
      else fwd_raw[s*SELW +: SELW] = sel;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    start_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (id_valid) begin
          if (hazard) begin
            stall_c = 1'b1;
          end else if (op_mtc0) begin
            stall_c = 1'b1;
            cnt_d   = SELW'(NSTG - 1);
            state_d = CP0WAIT;
          end else if (op_div) begin
            stall_c = 1'b1;
            start_c = 1'b1;
            state_d = DIVBUSY;
          end
        end
      end
      CP0WAIT: begin
        stall_c = 1'b1;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (cnt_d == '0) state_d = RELEASE;
      end
      DIVBUSY: begin
        stall_c = 1'b1;
        if (div_done) state_d = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset level also masks outputs so an in-flight stall drops at once.
  assign stall     = resetn & stall_c;
  assign div_start = resetn & start_c;
  assign ex_bubble = stall & id_valid;
  assign fwd_sel   = (resetn && id_valid) ? fwd_raw : '0;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (stall && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) perf_q <= '0;
    else perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected output rows are queued as
// stimulus is applied and popped when outputs are sampled at the falling edge.
module tb_hazard_ctrl;

  localparam int NSRC = 2;
  localparam int NSTG = 3;
  localparam int AW   = 5;
  localparam int SELW = 2;

  logic                 clk;
  logic                 resetn;
  logic                 id_valid;
  logic [NSRC*AW-1:0]   src_addr;
  logic [NSTG-1:0]      stg_valid;
  logic [NSTG*AW-1:0]   stg_dst;
  logic [NSTG-1:0]      stg_load;
  logic                 op_mtc0;
  logic                 op_div;
  logic                 div_done;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall;
  logic                 ex_bubble;
  logic                 div_start;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0]          perf_stall_cycles;
`endif

  hazard_ctrl #(.NSRC(NSRC), .NSTG(NSTG), .AW(AW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .id_valid  (id_valid),
    .src_addr  (src_addr),
    .stg_valid (stg_valid),
    .stg_dst   (stg_dst),
    .stg_load  (stg_load),
    .op_mtc0   (op_mtc0),
    .op_div    (op_div),
    .div_done  (div_done),
    .fwd_sel   (fwd_sel),
    .stall     (stall),
    .ex_bubble (ex_bubble),
    .div_start (div_start)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fwd_sel[3:0], stall, ex_bubble, div_start}
  logic [6:0] sbq[$];
  logic [6:0] exp_v;
  logic [6:0] act_v;
  int n_cmp;
  int n_bad;

  task automatic set_idle();
    id_valid  = 1'b0;
    src_addr  = '0;
    stg_valid = '0;
    stg_dst   = '0;
    stg_load  = '0;
    op_mtc0   = 1'b0;
    op_div    = 1'b0;
    div_done  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    set_idle();
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    id_valid  = 1'b1;
    src_addr  = {5'd9, 5'd5};
    stg_valid = 3'b011;
    stg_dst   = {5'd0, 5'd9, 5'd5};
    stg_load  = 3'b001;
    op_div    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(7'b0000_000);
      @(negedge clk);
      act_v = {fwd_sel, stall, ex_bubble, div_start};
      exp_v = sbq.pop_front();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset[%0d] got %b want %b", i, act_v, exp_v);
      end
      next_cycle();
    end
    set_idle();
    resetn = 1'b1;
    next_cycle();
  endtask

  task automatic test_forward();
    id_valid  = 1'b1;
    src_addr  = {5'd3, 5'd5};
    stg_valid = 3'b111;
    stg_dst   = {5'd3, 5'd5, 5'd5};
    stg_load  = 3'b000;
    sbq.push_back({2'd3, 2'd1, 3'b000});
    @(negedge clk);
    act_v = {fwd_sel, stall, ex_bubble, div_start};
    exp_v = sbq.pop_front();
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL forward got %b want %b", act_v, exp_v);
    end
    next_cycle();
    set_idle();
  endtask

  task automatic test_load_hazard();
    logic [6:0] rows [2];
    rows[0] = {2'd0, 2'd0, 3'b110};
    rows[1] = {2'd2, 2'd0, 3'b000};
    for (int i = 0; i < 2; i++) begin
      id_valid = 1'b1;
      src_addr = {5'd7, 5'd1};
      if (i == 0) begin
        stg_valid = 3'b001;
        stg_dst   = {5'd0, 5'd0, 5'd7};
        stg_load  = 3'b001;
      end else begin
        stg_valid = 3'b010;
        stg_dst   = {5'd0, 5'd7, 5'd0};
        stg_load  = 3'b000;
      end
      sbq.push_back(rows[i]);
      @(negedge clk);
      act_v = {fwd_sel, stall, ex_bubble, div_start};
      exp_v = sbq.pop_front();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL load_hazard[%0d] got %b want %b", i, act_v, exp_v);
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_zero_and_gate();
    for (int i = 0; i < 2; i++) begin
      id_valid  = (i == 0);
      stg_valid = 3'b111;
      stg_load  = 3'b000;
      if (i == 0) begin
        src_addr = {5'd0, 5'd0};
        stg_dst  = '0;
      end else begin
        src_addr = {5'd4, 5'd4};
        stg_dst  = {5'd4, 5'd4, 5'd4};
        stg_load = 3'b001;
        op_div   = 1'b1;
      end
      sbq.push_back(7'b0000_000);
      @(negedge clk);
      act_v = {fwd_sel, stall, ex_bubble, div_start};
      exp_v = sbq.pop_front();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL zero_gate[%0d] got %b want %b", i, act_v, exp_v);
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_mtc0();
    logic [6:0] rows [5];
    rows[0] = 7'b0000_110;
    rows[1] = 7'b0000_110;
    rows[2] = 7'b0000_100;
    rows[3] = 7'b0000_000;
    rows[4] = 7'b0000_000;
    for (int i = 0; i < 5; i++) begin
      id_valid = (i != 2);
      op_mtc0  = (i < 4);
      op_div   = (i == 1);
      sbq.push_back(rows[i]);
      @(negedge clk);
      act_v = {fwd_sel, stall, ex_bubble, div_start};
      exp_v = sbq.pop_front();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL mtc0[%0d] got %b want %b", i, act_v, exp_v);
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_div();
    pulse_reset();
    for (int i = 0; i < 13; i++) begin
      id_valid = 1'b1;
      op_div   = (i < 12);
      div_done = (i == 10);
      if (i == 0) sbq.push_back(7'b0000_111);
      else if (i < 11) sbq.push_back(7'b0000_110);
      else sbq.push_back(7'b0000_000);
      @(negedge clk);
      act_v = {fwd_sel, stall, ex_bubble, div_start};
      exp_v = sbq.pop_front();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL div[%0d] got %b want %b", i, act_v, exp_v);
      end
`ifdef HAZARD_CTRL_PERF_EN
      if (i == 11) begin
        n_cmp++;
        if (perf_stall_cycles !== 32'd11) begin
          n_bad++;
          $display("FAIL perf got %0d want 11", perf_stall_cycles);
        end
      end
`endif
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_reset_abort();
    logic [6:0] rows [6];
    rows[0] = 7'b0000_111;
    rows[1] = 7'b0000_110;
    rows[2] = 7'b0000_110;
    rows[3] = 7'b0000_000;
    rows[4] = 7'b0000_000;
    rows[5] = 7'b0000_000;
    for (int i = 0; i < 6; i++) begin
      id_valid = (i != 3);
      op_div   = (i < 3);
      resetn   = (i != 3);
      div_done = (i >= 4);
      sbq.push_back(rows[i]);
      @(negedge clk);
      act_v = {fwd_sel, stall, ex_bubble, div_start};
      exp_v = sbq.pop_front();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset_abort[%0d] got %b want %b", i, act_v, exp_v);
      end
      next_cycle();
    end
    set_idle();
    resetn = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    set_idle();
    resetn = 1'b0;
    next_cycle();
    test_reset();
    test_forward();
    test_load_hazard();
    test_zero_and_gate();
    test_mtc0();
    test_div();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 2: number of ID-stage source operands.
REQ-002 SHALL have parameter NSTG, default 3: forwarding stages, index 0=EX, 1=MEM, 2=WB.
REQ-003 SHALL have parameter AW, default 5: register address width.
REQ-004 SHALL define SELW = ceil(log2(NSTG+1)); it is derived, not overridable.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port id_valid  in  1  ID holds a valid instruction.
REQ-008 SHALL have port src_addr  in  NSRC*AW  source register addresses, source s at [s*AW +: AW].
REQ-009 SHALL have port stg_valid  in  NSTG  stage k holds a valid writing instruction.
REQ-010 SHALL have port stg_dst  in  NSTG*AW  stage k destination, packed like src_addr.
REQ-011 SHALL have port stg_load  in  NSTG  stage k result not yet available (load in flight).
REQ-012 SHALL have port op_mtc0  in  1  ID instruction is mtc0.
REQ-013 SHALL have port op_div  in  1  ID instruction is multi-cycle mul/div.
REQ-014 SHALL have port div_done  in  1  divider result ready, one-cycle pulse.
REQ-015 SHALL have port fwd_sel  out  NSRC*SELW  per source: 0=regfile, k+1=forward from stage k.
REQ-016 SHALL have port stall  out  1  freeze PC/IF/ID.
REQ-017 SHALL have port ex_bubble  out  1  insert NOP into EX.
REQ-018 SHALL have port div_start  out  1  one-cycle divider launch pulse.

Function
REQ-019 SHALL compute match(s,k) = stg_valid[k] & stg_dst_k!=0 & src_s==stg_dst_k.
REQ-020 SHALL select, per source, the lowest matching k (youngest producer); on no match, fwd_sel=0.
REQ-021 SHALL raise data hazard when the selected stage has stg_load=1; in that case fwd_sel=0 for that source.
REQ-022 SHALL implement FSM states IDLE, CP0WAIT, DIVBUSY and RELEASE, plus a counter cnt of width SELW.
REQ-023 SHALL, in IDLE with id_valid and data hazard, assert stall combinationally and remain in IDLE; hazard has priority over mtc0 and div.
REQ-024 SHALL, in IDLE with id_valid, op_mtc0 and no hazard, assert stall, load cnt=NSTG-1 and enter CP0WAIT.
REQ-025 SHALL, in CP0WAIT, assert stall and decrement cnt; at cnt==0 it enters RELEASE.
REQ-026 SHALL, in IDLE with id_valid, op_div, no hazard and no op_mtc0, pulse div_start for exactly one cycle, assert stall and enter DIVBUSY.
REQ-027 SHALL, in DIVBUSY, assert stall until div_done=1; on that cycle stall remains 1 and the next state is RELEASE.
REQ-028 SHALL, in RELEASE, drive stall=0 for one cycle so the ID instruction advances without retriggering, then return to IDLE.
REQ-029 SHALL ignore div_done outside DIVBUSY and ignore op_mtc0/op_div in non-IDLE states.
REQ-030 SHALL drive ex_bubble = stall & id_valid.
REQ-031 SHALL gate fwd_sel, stall, ex_bubble and div_start to 0 when id_valid=0, except that stall stays 1 in CP0WAIT and DIVBUSY.

Reset
REQ-032 SHALL, while resetn=0, asynchronously force state=IDLE and cnt=0, and force all outputs to 0.
REQ-033 SHALL, on reset asserted in CP0WAIT or DIVBUSY, abort and drop stall immediately; the first cycle after release behaves as IDLE.

Configuration
REQ-034 SHALL, when HAZARD_CTRL_PERF_EN is defined, add output perf_stall_cycles (32 bits), which counts cycles with stall=1, saturates at 0xFFFFFFFF and resets to 0.
REQ-035 SHALL, when HAZARD_CTRL_PERF_EN is undefined, omit the port and counter with no other behavioural change.

Verification
REQ-036 SHALL cover: src0=5, EX dst=5 non-load, MEM dst=5 -> fwd_sel[0]=1, stall=0.
REQ-037 SHALL cover: src1=7, EX dst=7 stg_load=1 -> stall=1, ex_bubble=1, fwd_sel[1]=0; next cycle load in MEM with stg_load=0 -> fwd_sel[1]=2, stall=0.
REQ-038 SHALL cover: src0=0, all stg_dst=0 valid -> fwd_sel=0, stall=0.
REQ-039 SHALL cover: mtc0 in ID, NSTG=3 -> stall high 3 cycles, low on the 4th (RELEASE), then IDLE.
REQ-040 SHALL cover: op_div in ID -> div_start for 1 cycle; div_done after 10 cycles -> stall for 11 cycles, 0 on the 12th; perf_stall_cycles=11 with macro.
REQ-041 SHALL cover: resetn pulled low mid-DIVBUSY -> stall=0 that cycle, state IDLE, later div_done ignored.
